jtframe_scan_dim: RTL and testbench

Scanline dimmer placed directly downstream of the bandwidth-limiting colour filter, before the video DAC/scaler output. It receives the filtered W-bit RGB with its aligned HS/VS/HB/VB. On alternate lines it attenuates colour by a selectable amount to emulate CRT scanline gaps. It forces colour to black during blanking and delays all signals by one pixel sample so that syncs stay aligned with colour.

---
 rtl/jtframe_scan_pkg.sv | 9 +
 rtl/jtframe_scan_dim_if.sv | 22 ++
 rtl/jtframe_scan_atten.sv | 25 ++
 rtl/jtframe_scan_dim.sv | 103 ++++++++++
 tb/tb_jtframe_scan_dim.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_scan_pkg.sv
// Shared dim-mode encodings for the scanline dimmer slice.
package jtframe_scan_pkg;

  localparam logic [1:0] SCAN_OFF = 2'd0;
  localparam logic [1:0] SCAN_25  = 2'd1;
  localparam logic [1:0] SCAN_50  = 2'd2;
  localparam logic [1:0] SCAN_75  = 2'd3;

endpackage

// File: rtl/jtframe_scan_dim_if.sv
// Video bus between the colour filter, the scanline dimmer and the output stage.
interface jtframe_scan_dim_if #(parameter int W = 5) ();

  logic         spl_in;
  logic [W-1:0] r_in, g_in, b_in;
  logic         HS_in, VS_in, HB_in, VB_in;
  logic [1:0]   mode;
  logic [W-1:0] r_out, g_out, b_out;
  logic         HS_out, VS_out, HB_out, VB_out;
  logic         line_odd;

  modport master (
    output spl_in, r_in, g_in, b_in, HS_in, VS_in, HB_in, VB_in, mode,
    input  r_out, g_out, b_out, HS_out, VS_out, HB_out, VB_out, line_odd
  );

  modport slave (
    input  spl_in, r_in, g_in, b_in, HS_in, VS_in, HB_in, VB_in, mode,
    output r_out, g_out, b_out, HS_out, VS_out, HB_out, VB_out, line_odd
  );

endinterface

// File: rtl/jtframe_scan_atten.sv
// Per-channel combinational attenuator: off, 25 %, 50 % or 75 % reduction.
module jtframe_scan_atten
  import jtframe_scan_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] value,
  input  logic [1:0]   mode,
  input  logic         enable,
  output logic [W-1:0] result
);

  always_comb begin
    result = value;
    if (enable) begin
      case (mode)
        SCAN_25: result = value - (value >> 2);
        SCAN_50: result = value >> 1;
        SCAN_75: result = value >> 2;
        default: result = value;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_scan_dim.sv
// Scanline dimmer: alternate-line attenuation, blanking to black, one-sample delay.
// Define JTFRAME_SCAN_ALT_EN to swap dimmed lines every frame (interlace-like).
module jtframe_scan_dim
  import jtframe_scan_pkg::*;
#(
  parameter int W = 5
) (
  input  logic                clk,
  input  logic                rst,
  jtframe_scan_dim_if.slave   bus
);

  logic         hs_l, vs_l;
  logic         parity;
  logic [1:0]   mode_l;
  logic         hs_rise, vs_rise;
  logic         field_next;
  logic         parity_next;
  logic [1:0]   mode_next;
  logic         blank;
  logic [W-1:0] r_att, g_att, b_att;

  assign hs_rise = bus.HS_in & ~hs_l;
  assign vs_rise = bus.VS_in & ~vs_l;
  assign blank   = bus.HB_in | bus.VB_in;

`ifdef JTFRAME_SCAN_ALT_EN
  logic field;

  assign field_next = field ^ vs_rise;

  always_ff @(posedge clk) begin
    if (rst)             field <= 1'b0;
    else if (bus.spl_in) field <= field_next;
  end
`else
  assign field_next = 1'b0;
`endif

  // VS wins over a coincident HS edge; the new parity and mode apply to this sample
  always_comb begin
    parity_next = parity;
    mode_next   = mode_l;
    if (vs_rise) begin
      parity_next = field_next;
      mode_next   = bus.mode;
    end else if (hs_rise) begin
      parity_next = ~parity;
    end
  end

  jtframe_scan_atten #(.W(W)) u_atten_r (
    .value  (bus.r_in),
    .mode   (mode_next),
    .enable (parity_next),
    .result (r_att)
  );

  jtframe_scan_atten #(.W(W)) u_atten_g (
    .value  (bus.g_in),
    .mode   (mode_next),
    .enable (parity_next),
    .result (g_att)
  );

  jtframe_scan_atten #(.W(W)) u_atten_b (
    .value  (bus.b_in),
    .mode   (mode_next),
    .enable (parity_next),
    .result (b_att)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_l         <= 1'b0;
      vs_l         <= 1'b0;
      parity       <= 1'b0;
      mode_l       <= SCAN_OFF;
      bus.r_out    <= '0;
      bus.g_out    <= '0;
      bus.b_out    <= '0;
      bus.HS_out   <= 1'b0;
      bus.VS_out   <= 1'b0;
      bus.HB_out   <= 1'b0;
      bus.VB_out   <= 1'b0;
      bus.line_odd <= 1'b0;
    end else if (bus.spl_in) begin
      hs_l         <= bus.HS_in;
      vs_l         <= bus.VS_in;
      parity       <= parity_next;
      mode_l       <= mode_next;
      bus.r_out    <= blank ? '0 : r_att;
      bus.g_out    <= blank ? '0 : g_att;
      bus.b_out    <= blank ? '0 : b_att;
      bus.HS_out   <= bus.HS_in;
      bus.VS_out   <= bus.VS_in;
      bus.HB_out   <= bus.HB_in;
      bus.VB_out   <= bus.VB_in;
      bus.line_odd <= parity_next;
    end
  end

endmodule

// File: tb/tb_jtframe_scan_dim.sv
// Self-checking bench for jtframe_scan_dim against a frame/line behavioural model.
module tb_jtframe_scan_dim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  jtframe_scan_dim_if #(.W(5)) bus ();

  jtframe_scan_dim #(.W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: previous syncs, line parity, frame mode, field
  logic       m_hs, m_vs, m_par, m_field;
  logic [1:0] m_mode;
  logic [4:0] e_r, e_g, e_b;
  logic       e_hs, e_vs, e_hb, e_vb, e_odd;

  function automatic logic [4:0] dim(input logic [4:0] c, input logic [1:0] md, input logic p);
    int v;
    v = int'(c);
    if (!p) return c;
    case (md)
      2'd1:    v = v - v / 4;
      2'd2:    v = v / 2;
      2'd3:    v = v / 4;
      default: v = v;
    endcase
    return v[4:0];
  endfunction

  task automatic model_reset();
    m_hs = 0; m_vs = 0; m_par = 0; m_field = 0; m_mode = 0;
    e_r = 0; e_g = 0; e_b = 0;
    e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0; e_odd = 0;
  endtask

  task automatic model_sample();
    if (bus.VS_in && !m_vs) begin
`ifdef JTFRAME_SCAN_ALT_EN
      m_field = !m_field;
      m_par   = m_field;
`else
      m_par   = 1'b0;
`endif
      m_mode  = bus.mode;
    end else if (bus.HS_in && !m_hs) begin
      m_par = !m_par;
    end
    if (bus.HB_in || bus.VB_in) begin
      e_r = 0; e_g = 0; e_b = 0;
    end else begin
      e_r = dim(bus.r_in, m_mode, m_par);
      e_g = dim(bus.g_in, m_mode, m_par);
      e_b = dim(bus.b_in, m_mode, m_par);
    end
    e_hs = bus.HS_in; e_vs = bus.VS_in; e_hb = bus.HB_in; e_vb = bus.VB_in;
    e_odd = m_par;
    m_hs = bus.HS_in;
    m_vs = bus.VS_in;
  endtask

  // One clock; the model advances only when the strobe is set
  task automatic step(input logic s);
    @(negedge clk);
    bus.spl_in = s;
    @(posedge clk);
    #1;
    if (s && !rst) model_sample();
    bus.spl_in = 1'b0;
  endtask

  // One pixel with the strobe every second clock
  task automatic sample();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic set_pix(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    bus.r_in = r; bus.g_in = g; bus.b_in = b;
  endtask

  task automatic hs_pulse();
    bus.HS_in = 1'b1; sample();
    bus.HS_in = 1'b0; sample();
  endtask

  task automatic vs_pulse();
    bus.VS_in = 1'b1; sample();
    bus.VS_in = 1'b0; sample();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1);
    step(1'b0);
    model_reset();
    checks++;
    if ({bus.r_out, bus.g_out, bus.b_out, bus.HS_out, bus.VS_out, bus.HB_out,
         bus.VB_out, bus.line_odd} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got r=%0d g=%0d b=%0d syncs=%b%b%b%b odd=%b, want all 0",
               bus.r_out, bus.g_out, bus.b_out, bus.HS_out, bus.VS_out, bus.HB_out,
               bus.VB_out, bus.line_odd);
    end
    rst = 1'b0;
  endtask

  task automatic test_no_edge();
    bus.mode = 2'd2;
    set_pix(5'd20, 5'd9, 5'd3);
    for (int unsigned i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (bus.r_out !== 5'd20 || bus.line_odd !== 1'b0) begin
        errors++;
        $display("FAIL no_edge_pass: got r=%0d odd=%b, want r=20 odd=0", bus.r_out, bus.line_odd);
      end
    end
  endtask

  task automatic test_lines();
    bus.mode = 2'd2;
    set_pix(5'd20, 5'd20, 5'd20);
    vs_pulse();
    bus.HS_in = 1'b1; sample();
    checks++;
    if (bus.line_odd !== e_odd || bus.r_out !== e_r) begin
      errors++;
      $display("FAIL line_first_hs: got odd=%b r=%0d, want odd=%b r=%0d", bus.line_odd, bus.r_out, e_odd, e_r);
    end
`ifndef JTFRAME_SCAN_ALT_EN
    checks++;
    if (bus.line_odd !== 1'b1 || bus.r_out !== 5'd10) begin
      errors++;
      $display("FAIL line_odd_dim: got odd=%b r=%0d, want odd=1 r=10", bus.line_odd, bus.r_out);
    end
`endif
    bus.HS_in = 1'b0; sample();
    bus.HS_in = 1'b1; sample();
    checks++;
    if (bus.line_odd !== e_odd || bus.r_out !== e_r) begin
      errors++;
      $display("FAIL line_second_hs: got odd=%b r=%0d, want odd=%b r=%0d", bus.line_odd, bus.r_out, e_odd, e_r);
    end
`ifndef JTFRAME_SCAN_ALT_EN
    checks++;
    if (bus.line_odd !== 1'b0 || bus.r_out !== 5'd20) begin
      errors++;
      $display("FAIL line_even_pass: got odd=%b r=%0d, want odd=0 r=20", bus.line_odd, bus.r_out);
    end
`endif
    bus.HS_in = 1'b0; sample();
  endtask

  task automatic test_modes();
    logic [1:0] md;
    logic [4:0] want;
    for (int unsigned k = 0; k < 2; k++) begin
      md   = (k == 0) ? 2'd1 : 2'd3;
      want = (k == 0) ? 5'd24 : 5'd7;
      bus.mode = md;
      vs_pulse();
      for (int unsigned n = 0; n < 3 && !m_par; n++) hs_pulse();
      set_pix(5'd0, 5'd31, 5'd0);
      sample();
      checks++;
      if (!m_par || bus.g_out !== want || bus.line_odd !== 1'b1) begin
        errors++;
        $display("FAIL mode%0d_g31: got g=%0d odd=%b, want g=%0d odd=1", md, bus.g_out, bus.line_odd, want);
      end
    end
  endtask

  task automatic test_midframe_mode();
    bus.mode = 2'd2;
    vs_pulse();
    for (int unsigned n = 0; n < 3 && !m_par; n++) hs_pulse();
    bus.mode = 2'd3;
    set_pix(5'd20, 5'd20, 5'd20);
    sample();
    checks++;
    if (bus.r_out !== 5'd10) begin
      errors++;
      $display("FAIL midframe_keep50: got r=%0d, want 10", bus.r_out);
    end
    vs_pulse();
    for (int unsigned n = 0; n < 3 && !m_par; n++) hs_pulse();
    sample();
    checks++;
    if (bus.r_out !== 5'd5) begin
      errors++;
      $display("FAIL next_frame_75: got r=%0d, want 5", bus.r_out);
    end
  endtask

  task automatic test_blank();
    set_pix(5'd31, 5'd31, 5'd31);
    bus.HB_in = 1'b1;
    sample();
    checks++;
    if (bus.b_out !== 5'd0 || bus.HB_out !== 1'b1) begin
      errors++;
      $display("FAIL hblank_black: got b=%0d HB_out=%b, want b=0 HB_out=1", bus.b_out, bus.HB_out);
    end
    bus.HB_in = 1'b0;
    bus.VB_in = 1'b1;
    bus.mode  = 2'd0;
    sample();
    checks++;
    if ({bus.r_out, bus.g_out, bus.b_out} !== 15'd0 || bus.VB_out !== 1'b1) begin
      errors++;
      $display("FAIL vblank_black: got rgb=%h VB_out=%b, want rgb=0 VB_out=1",
               {bus.r_out, bus.g_out, bus.b_out}, bus.VB_out);
    end
    bus.VB_in = 1'b0;
    sample();
  endtask

  task automatic test_hs_vs_same();
    logic prev;
    prev = 1'b0;
    for (int unsigned f = 0; f < 3; f++) begin
      bus.HS_in = 1'b1; bus.VS_in = 1'b1;
      sample();
      checks++;
      if (bus.line_odd !== e_odd) begin
        errors++;
        $display("FAIL hsvs_same_f%0d: got odd=%b, want %b", f, bus.line_odd, e_odd);
      end
`ifdef JTFRAME_SCAN_ALT_EN
      if (f > 0) begin
        checks++;
        if (bus.line_odd === prev) begin
          errors++;
          $display("FAIL hsvs_alternate_f%0d: got odd=%b, want %b", f, bus.line_odd, ~prev);
        end
      end
`else
      checks++;
      if (bus.line_odd !== 1'b0) begin
        errors++;
        $display("FAIL hsvs_no_toggle_f%0d: got odd=%b, want 0", f, bus.line_odd);
      end
`endif
      prev = bus.line_odd;
      bus.HS_in = 1'b0; bus.VS_in = 1'b0;
      sample();
      hs_pulse();
    end
  endtask

  task automatic test_random();
    logic s;
    for (int unsigned i = 0; i < 600; i++) begin
      set_pix(5'($urandom), 5'($urandom), 5'($urandom));
      bus.HS_in = ($urandom % 4) == 0;
      bus.VS_in = ($urandom % 24) == 0;
      bus.HB_in = ($urandom % 8) == 0;
      bus.VB_in = ($urandom % 16) == 0;
      bus.mode  = 2'($urandom);
      s = ($urandom % 3) != 0;
      step(s);
      checks++;
      if (bus.r_out !== e_r || bus.g_out !== e_g || bus.b_out !== e_b ||
          bus.HS_out !== e_hs || bus.VS_out !== e_vs || bus.HB_out !== e_hb ||
          bus.VB_out !== e_vb || bus.line_odd !== e_odd) begin
        errors++;
        $display("FAIL random_%0d: got rgb=%0d,%0d,%0d s=%b%b%b%b odd=%b, want rgb=%0d,%0d,%0d s=%b%b%b%b odd=%b",
                 i, bus.r_out, bus.g_out, bus.b_out, bus.HS_out, bus.VS_out, bus.HB_out,
                 bus.VB_out, bus.line_odd, e_r, e_g, e_b, e_hs, e_vs, e_hb, e_vb, e_odd);
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.mode = 2'd0;
    vs_pulse();
    bus.HS_in = 1'b1;
    set_pix(5'd17, 5'd23, 5'd29);
    sample();
    @(negedge clk);
    rst = 1'b1;
    bus.spl_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.r_out, bus.g_out, bus.b_out, bus.HS_out, bus.VS_out, bus.HB_out,
         bus.VB_out, bus.line_odd} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset: got r=%0d g=%0d b=%0d syncs=%b%b%b%b odd=%b, want all 0",
               bus.r_out, bus.g_out, bus.b_out, bus.HS_out, bus.VS_out, bus.HB_out,
               bus.VB_out, bus.line_odd);
    end
    bus.spl_in = 1'b0;
    rst = 1'b0;
    model_reset();
    bus.HS_in = 1'b0;
    bus.mode  = 2'd3;
    set_pix(5'd20, 5'd20, 5'd20);
    hs_pulse();
    sample();
    checks++;
    if (bus.r_out !== 5'd20) begin
      errors++;
      $display("FAIL post_reset_undimmed: got r=%0d, want 20", bus.r_out);
    end
  endtask

  initial begin
    bus.spl_in = 1'b0;
    bus.r_in = '0; bus.g_in = '0; bus.b_in = '0;
    bus.HS_in = 1'b0; bus.VS_in = 1'b0; bus.HB_in = 1'b0; bus.VB_in = 1'b0;
    bus.mode = 2'd0;
    model_reset();
    test_reset();
    test_no_edge();
    test_lines();
    test_modes();
    test_midframe_mode();
    test_blank();
    test_hs_vs_same();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
